yarvi_bus_arb: RTL and testbench

YARVI_BUS_ARB -- requirements
Module: yarvi_bus_arb

---
 rtl/yarvi_bus_arb.sv | 148 ++++++++++++++
 tb/tb_yarvi_bus_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_bus_arb.sv
// Round-robin arbiter: N masters share one slave port.
// Read responses are routed back to the issuing master through an in-order tag FIFO.
module yarvi_bus_arb #(
    parameter int N_MASTERS       = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_MASTERS-1:0]             m_req_read,
    input  logic [N_MASTERS-1:0]             m_req_write,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_req_address,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_req_data,
    output logic [N_MASTERS-1:0]             m_req_ready,
    output logic [N_MASTERS-1:0]             m_res_valid,
    output logic [DATA_WIDTH-1:0]            m_res_data,
    input  logic                             s_req_ready,
    output logic                             s_req_read,
    output logic                             s_req_write,
    output logic [ADDR_WIDTH-1:0]            s_req_address,
    output logic [DATA_WIDTH-1:0]            s_req_data,
    input  logic                             s_res_valid,
    input  logic [DATA_WIDTH-1:0]            s_res_data,
    output logic                             protocol_error
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] r_tag [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_protocol_error;

    logic [N_MASTERS-1:0] w_req;
    logic                 w_gnt_valid;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_gnt_read;
    logic                 w_gnt_write;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic                 w_pop;
    logic                 w_blocked;
    logic                 w_accept;
    logic                 w_push;
    logic [IDX_W-1:0]     w_head_tag;

    assign w_req = m_req_read | m_req_write;

    // Search starts one past the last accepted master so every requester gets a turn.
    always_comb begin : rr_search
        int cand;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = (int'(r_last_grant) + k) % N_MASTERS;
            if (!w_gnt_valid && w_req[cand]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        w_gnt_read    = 1'b0;
        w_gnt_write   = 1'b0;
        s_req_address = '0;
        s_req_data    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_gnt_valid && (w_gnt_idx == IDX_W'(i))) begin
                w_gnt_write   = m_req_write[i];
                w_gnt_read    = m_req_read[i] & ~m_req_write[i];
                s_req_address = m_req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_req_data    = m_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_head_tag   = r_tag[r_rd_ptr];

    // A response popping this cycle frees a slot, so a read at full occupancy may still proceed.
    assign w_pop     = ~reset & s_res_valid & ~w_fifo_empty;
    assign w_blocked = w_gnt_read & w_fifo_full & ~w_pop;
    assign w_accept  = ~reset & w_gnt_valid & s_req_ready & ~w_blocked;
    assign w_push    = w_accept & w_gnt_read;

    assign s_req_read  = ~reset & w_gnt_read & ~w_blocked;
    assign s_req_write = ~reset & w_gnt_write;

    always_comb begin
        m_req_ready = '0;
        m_res_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_accept && (w_gnt_idx == IDX_W'(i))) begin
                m_req_ready[i] = 1'b1;
            end
            if (w_pop && (w_head_tag == IDX_W'(i))) begin
                m_res_valid[i] = 1'b1;
            end
        end
    end

    assign m_res_data     = s_res_data;
    assign protocol_error = r_protocol_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant     <= IDX_W'(N_MASTERS - 1);
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_gnt_idx;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (s_res_valid && w_fifo_empty) begin
                r_protocol_error <= 1'b1;
            end
        end
    end

    // Tag storage holds data only; validity is tracked by the count and pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr] <= w_gnt_idx;
        end
    end

endmodule

// File: tb/tb_yarvi_bus_arb.sv
// Bench for yarvi_bus_arb: directed scenarios plus random traffic against a queue-based model.
module tb_yarvi_bus_arb;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      m_req_read, m_req_write, m_req_ready, m_res_valid;
    logic [N*AW-1:0]   m_req_address;
    logic [N*DW-1:0]   m_req_data;
    logic [DW-1:0]     m_res_data;
    logic              s_req_ready, s_req_read, s_req_write;
    logic [AW-1:0]     s_req_address;
    logic [DW-1:0]     s_req_data;
    logic              s_res_valid;
    logic [DW-1:0]     s_res_data;
    logic              protocol_error;

    yarvi_bus_arb #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req_read(m_req_read), .m_req_write(m_req_write),
        .m_req_address(m_req_address), .m_req_data(m_req_data),
        .m_req_ready(m_req_ready), .m_res_valid(m_res_valid), .m_res_data(m_res_data),
        .s_req_ready(s_req_ready), .s_req_read(s_req_read), .s_req_write(s_req_write),
        .s_req_address(s_req_address), .s_req_data(s_req_data),
        .s_res_valid(s_res_valid), .s_res_data(s_res_data),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int last_g;
    int tagq[$];
    bit perr;

    logic [N-1:0]  obs_ready, obs_resv;
    logic          obs_perr, obs_swrite, obs_sread;
    logic [AW-1:0] obs_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        m_req_read  = '0;
        m_req_write = '0;
        s_req_ready = 1'b1;
        s_res_valid = 1'b0;
        s_res_data  = '0;
    endtask

    // Inputs are set just after a falling edge; outputs checked mid-low phase, model commits at the rising edge.
    task automatic step();
        int g;
        bit pop, isrd, blocked, acc;
        logic [N-1:0]  req, e_ready, e_resv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        #2;
        req = m_req_read | m_req_write;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last_g + k) % N;
            if (g < 0 && req[c]) g = c;
        end
        pop     = !reset && s_res_valid && tagq.size() > 0;
        isrd    = (g >= 0) && m_req_read[g] && !m_req_write[g];
        blocked = isrd && tagq.size() == MAXO && !pop;
        acc     = !reset && (g >= 0) && s_req_ready && !blocked;
        e_ready = '0;
        if (acc) e_ready[g] = 1'b1;
        e_resv = '0;
        if (pop) e_resv[tagq[0]] = 1'b1;
        e_addr = (g >= 0) ? m_req_address[g*AW +: AW] : '0;
        e_data = (g >= 0) ? m_req_data[g*DW +: DW] : '0;

        chk("m_req_ready", m_req_ready, e_ready);
        chk("m_res_valid", m_res_valid, e_resv);
        chk("s_req_read", s_req_read, !reset && isrd && !blocked);
        chk("s_req_write", s_req_write, !reset && (g >= 0) && m_req_write[g]);
        chk("s_req_address", s_req_address, e_addr);
        chk("s_req_data", s_req_data, e_data);
        chk("m_res_data", m_res_data, s_res_data);
        chk("protocol_error", protocol_error, perr);

        obs_ready  = m_req_ready;
        obs_resv   = m_res_valid;
        obs_perr   = protocol_error;
        obs_swrite = s_req_write;
        obs_sread  = s_req_read;
        obs_addr   = s_req_address;

        @(posedge clk);
        if (reset) begin
            last_g = N - 1;
            tagq.delete();
            perr = 1'b0;
        end else begin
            if (s_res_valid) begin
                if (tagq.size() > 0) void'(tagq.pop_front());
                else perr = 1'b1;
            end
            if (acc) begin
                last_g = g;
                if (isrd) tagq.push_back(g);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        m_req_address = '0;
        m_req_data    = '0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        last_g = N - 1;
        tagq.delete();
        perr = 1'b0;

        // Outputs suppressed while reset is held, even with requests present
        m_req_write = '1;
        s_res_valid = 1'b1;
        step();
        chk("rst_ready", obs_ready, 0);
        chk("rst_resv", obs_resv, 0);
        reset = 1'b0;
        idle();
        step();
        chk("rst_perr", obs_perr, 0);

        // Two continuous writers alternate every cycle
        m_req_write = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alt_grant", obs_ready, (i % 2 == 0) ? 1 : 2);
        end

        // Four requesters: grant order 0,1,2,3,0
        do_reset();
        m_req_write = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr4_grant", obs_ready, 1 << (i % 4));
        end

        // Two reads, responses routed back in request order
        do_reset();
        m_req_address[0*AW +: AW] = 32'h100;
        m_req_address[1*AW +: AW] = 32'h200;
        m_req_read = 4'b0011;
        step();
        chk("rd0_ready", obs_ready, 1);
        chk("rd0_addr", obs_addr, 32'h100);
        m_req_read = 4'b0010;
        step();
        chk("rd1_ready", obs_ready, 2);
        chk("rd1_addr", obs_addr, 32'h200);
        idle();
        s_res_valid = 1'b1;
        s_res_data  = 32'hAAAA;
        step();
        chk("resp0_valid", obs_resv, 1);
        s_res_data = 32'hBBBB;
        step();
        chk("resp1_valid", obs_resv, 2);
        idle();
        step();
        chk("resp_perr", obs_perr, 0);

        // Tag FIFO full blocks the fifth read until a response frees a slot
        do_reset();
        m_req_read = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fill_ready", obs_ready, 1);
        end
        step();
        chk("full_ready", obs_ready, 0);
        chk("full_sread", obs_sread, 0);
        s_res_valid = 1'b1;
        s_res_data  = 32'h1234;
        step();
        chk("full_pop_ready", obs_ready, 1);
        chk("full_pop_resv", obs_resv, 1);
        m_req_read = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_resv", obs_resv, 1);
        end
        idle();
        step();
        chk("drain_perr", obs_perr, 0);

        // Slave stall: request held stable, accepted once ready returns
        do_reset();
        m_req_write = 4'b0010;
        m_req_address[1*AW +: AW] = 32'hCAFE0;
        s_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", obs_ready, 0);
            chk("stall_swrite", obs_swrite, 1);
            chk("stall_addr", obs_addr, 32'hCAFE0);
        end
        s_req_ready = 1'b1;
        step();
        chk("stall_accept", obs_ready, 2);

        // Spurious response sets a sticky error
        do_reset();
        s_res_valid = 1'b1;
        step();
        chk("spur_resv", obs_resv, 0);
        s_res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("spur_sticky", obs_perr, 1);
        end
        do_reset();
        step();
        chk("spur_cleared", obs_perr, 0);

        // Random traffic with occasional mid-operation resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset       = ($urandom_range(0, 99) == 0);
            m_req_read  = N'($urandom);
            m_req_write = N'($urandom) & N'($urandom);
            for (int i = 0; i < N; i++) begin
                m_req_address[i*AW +: AW] = $urandom;
                m_req_data[i*DW +: DW]    = $urandom;
            end
            s_req_ready = ($urandom_range(0, 3) != 0);
            s_res_valid = ($urandom_range(0, 2) == 0);
            s_res_data  = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
